// File: rtl/instr_issue_seq.sv
// -----------------------------------------------------------------------------
// instr_issue_seq
// Instruction fetch/issue sequencer. Fetches instruction words from an
// instruction memory over a req/ack handshake (variable latency), splits each
// word into opcode/rd/rs/rt and presents one instruction at a time to the
// decoder with an issue strobe. Stops on HALT (opcode 4'b1111) or at the last
// program word, and records any illegal opcode that had to be skipped.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active low
//   start      in   run program from PC 0 (honoured only in IDLE/DONE)
//   imem_req   out  instruction memory read request
//   imem_addr  out  read address (equals pc while imem_req=1)
//   imem_ack   in   imem_data valid this cycle (ignored outside FETCH)
//   imem_data  in   instruction word [19:16] op, [15:11] rd, [10:6] rs, [5:1] rt
//   opcode     out  opcode for the decoder, qualified by issue
//   rd/rs/rt   out  register addresses of the issued instruction
//   issue      out  instruction presented this cycle (1 cycle ALU, 2 cycles SW)
//   pc         out  current program counter
//   busy       out  high in FETCH/DECODE/ISSUE
//   done       out  high in DONE
//   illegal    out  sticky flag: an illegal opcode was skipped since last start
// -----------------------------------------------------------------------------
module instr_issue_seq #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 20,
  parameter int PROG_LEN = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [3:0]          opcode,
  output logic [4:0]          rd,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic                issue,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t               state_r, state_s;
  logic [ADDR_W-1:0]    pc_r, pc_s;
  logic                 imem_req_r, imem_req_s;
  logic [ADDR_W-1:0]    imem_addr_r, imem_addr_s;
  logic [3:0]           opcode_r, opcode_s;
  logic [4:0]           rd_r, rd_s;
  logic [4:0]           rs_r, rs_s;
  logic [4:0]           rt_r, rt_s;
  logic                 issue_r, issue_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 illegal_r, illegal_s;
  // Instruction register; bit 0 of the word carries no information.
  logic [INSTR_W-1:1]   ir_r, ir_s;
  // Set while an SW still owes its second issue cycle.
  logic                 sw_hold_r, sw_hold_s;
  logic [3:0]           ir_op_s;
  logic                 unused_lsb_s;

  assign ir_op_s      = ir_r[19:16];
  assign unused_lsb_s = imem_data[0];

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    imem_req_s  = imem_req_r;
    imem_addr_s = imem_addr_r;
    opcode_s    = opcode_r;
    rd_s        = rd_r;
    rs_s        = rs_r;
    rt_s        = rt_r;
    issue_s     = 1'b0;
    busy_s      = busy_r;
    done_s      = done_r;
    illegal_s   = illegal_r;
    ir_s        = ir_r;
    sw_hold_s   = 1'b0;

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s     = FETCH;
          pc_s        = PC_ZERO;
          imem_req_s  = 1'b1;
          imem_addr_s = PC_ZERO;
          busy_s      = 1'b1;
          done_s      = 1'b0;
          illegal_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      FETCH: begin
        if (imem_ack) begin
          ir_s       = imem_data[INSTR_W-1:1];
          imem_req_s = 1'b0;
          state_s    = DECODE;
        end else begin
          state_s = FETCH;
        end
      end

      DECODE: begin
        if (ir_op_s == OP_HALT) begin
          // HALT leaves pc pointing at the HALT word.
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else if (ir_op_s <= OP_SW) begin
          state_s   = ISSUE;
          issue_s   = 1'b1;
          opcode_s  = ir_op_s;
          rd_s      = ir_r[15:11];
          rs_s      = ir_r[10:6];
          rt_s      = ir_r[5:1];
          sw_hold_s = (ir_op_s == OP_SW);
        end else begin
          // Illegal opcode: skip it without an issue pulse and move on.
          illegal_s = 1'b1;
          if (pc_r == LAST_PC) begin
            state_s = DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s     = FETCH;
            pc_s        = pc_r + PC_ONE;
            imem_req_s  = 1'b1;
            imem_addr_s = pc_r + PC_ONE;
          end
        end
      end

      ISSUE: begin
        if (sw_hold_r) begin
          // Second SW cycle: keep the instruction on the bus unchanged.
          state_s = ISSUE;
          issue_s = 1'b1;
        end else if (pc_r == LAST_PC) begin
          state_s = DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s     = FETCH;
          pc_s        = pc_r + PC_ONE;
          imem_req_s  = 1'b1;
          imem_addr_s = pc_r + PC_ONE;
        end
      end

      default: begin
        state_s    = IDLE;
        imem_req_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= PC_ZERO;
      imem_req_r  <= 1'b0;
      imem_addr_r <= PC_ZERO;
      opcode_r    <= 4'b0000;
      rd_r        <= 5'b00000;
      rs_r        <= 5'b00000;
      rt_r        <= 5'b00000;
      issue_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      illegal_r   <= 1'b0;
      ir_r        <= {(INSTR_W-1){1'b0}};
      sw_hold_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      imem_req_r  <= imem_req_s;
      imem_addr_r <= imem_addr_s;
      opcode_r    <= opcode_s;
      rd_r        <= rd_s;
      rs_r        <= rs_s;
      rt_r        <= rt_s;
      issue_r     <= issue_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      illegal_r   <= illegal_s;
      ir_r        <= ir_s;
      sw_hold_r   <= sw_hold_s;
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = imem_addr_r;
  assign opcode    = opcode_r;
  assign rd        = rd_r;
  assign rs        = rs_r;
  assign rt        = rt_r;
  assign issue     = issue_r;
  assign pc        = pc_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_instr_issue_seq.sv
// -----------------------------------------------------------------------------
// tb_instr_issue_seq
// Random-program bench for instr_issue_seq. A program-level reference model
// walks each program image word by word and predicts the fetch addresses,
// every issue cycle (with its fields and clock index), the final pc, the
// illegal flag and the cycle on which done rises. An instruction-memory
// responder with per-fetch latency checks fetch addresses and request
// stability; a monitor pops expected issues whenever issue is high.
// -----------------------------------------------------------------------------
module tb_instr_issue_seq;

  localparam int ADDR_W   = 8;
  localparam int INSTR_W  = 20;
  localparam int PROG_LEN = 8;

  typedef struct {
    logic [3:0] op;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [7:0] pc;
    int         cyc;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [3:0]         opcode;
  logic [4:0]         rd, rs, rt;
  logic               issue;
  logic [ADDR_W-1:0]  pc;
  logic               busy, done, illegal;

  logic [INSTR_W-1:0] mem [256];
  exp_t               exp_q[$];
  int                 lat_q[$];
  int                 fetch_q[$];
  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_fail = 0;
  bit                 force_ack = 1'b0;

  instr_issue_seq #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .PROG_LEN(PROG_LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .imem_ack (imem_ack),
    .imem_data(imem_data),
    .opcode   (opcode),
    .rd       (rd),
    .rs       (rs),
    .rt       (rt),
    .issue    (issue),
    .pc       (pc),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory: serves each request after its scheduled latency,
  // and throws spurious acks with junk data while no request is pending.
  initial begin
    bit   in_req;
    int   cur_lat;
    int   wcnt;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0] rnd;
    in_req = 1'b0; cur_lat = 0; wcnt = 0; req_addr = '0;
    imem_ack = 1'b0; imem_data = '0;
    forever begin
      @(negedge clk);
      if (!imem_req) begin
        in_req   = 1'b0;
        rnd      = $urandom;
        imem_ack = force_ack || (rnd[1:0] == 2'b00);
        imem_data = rnd[19:0];
      end else begin
        if (!in_req) begin
          in_req   = 1'b1;
          cur_lat  = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
          wcnt     = 0;
          req_addr = imem_addr;
        end else begin
          chk("req_addr_stable", 64'(imem_addr), 64'(req_addr));
        end
        if (wcnt == cur_lat) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          if (fetch_q.size() == 0) begin
            chk("fetch_unexpected", 64'(imem_addr), 64'hFFFF);
          end else begin
            chk("fetch_addr", 64'(imem_addr), 64'(fetch_q.pop_front()));
          end
          in_req = 1'b0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end
    end
  end

  // Monitor: every cycle with issue high must match the next predicted issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && issue) begin
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 64'(opcode), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("issue_opcode", 64'(opcode), 64'(e.op));
          chk("issue_rd", 64'(rd), 64'(e.rd));
          chk("issue_rs", 64'(rs), 64'(e.rs));
          chk("issue_rt", 64'(rt), 64'(e.rt));
          chk("issue_pc", 64'(pc), 64'(e.pc));
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Reference model + run: predicts the whole program, starts it, waits for done.
  // lat_fixed < 0 selects a random latency per fetch.
  task automatic run_prog(input int lat_fixed);
    int t, dec, nxt, done_t, lat, p, pulse_at;
    bit ill, seen;
    logic [INSTR_W-1:0] w;
    logic [3:0] op;
    exp_t e;
    @(negedge clk);
    t = cyc + 1;          // edge on which start is taken
    p = 0; ill = 1'b0; done_t = 0;
    forever begin
      lat = (lat_fixed < 0) ? int'($urandom_range(0, 3)) : lat_fixed;
      lat_q.push_back(lat);
      fetch_q.push_back(p);
      w   = mem[p];
      op  = w[19:16];
      dec = t + lat + 1;
      if (op == 4'hF) begin
        done_t = dec + 1;
        break;
      end else if (op > 4'h6) begin
        ill = 1'b1;
        nxt = dec + 1;
      end else begin
        e.op = op; e.rd = w[15:11]; e.rs = w[10:6]; e.rt = w[5:1];
        e.pc = 8'(p); e.cyc = dec + 1;
        exp_q.push_back(e);
        if (op == 4'h6) begin
          e.cyc = dec + 2;
          exp_q.push_back(e);
        end
        nxt = dec + 1 + ((op == 4'h6) ? 2 : 1);
      end
      if (p == PROG_LEN - 1) begin
        done_t = nxt;
        break;
      end
      p++;
      t = nxt;
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_illegal_clr", 64'(illegal), 64'd0);
    pulse_at = $urandom_range(0, 6);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else if (c == pulse_at && busy) begin
        start = 1'b1;   // must be ignored while busy
      end else begin
        start = 1'b0;
      end
    end
    if (!seen) begin
      chk("done_timeout", 64'(done), 64'd1);
    end else begin
      chk("done_cycle", 64'(cyc), 64'(done_t));
      chk("done_pc", 64'(pc), 64'(p));
      chk("done_illegal", 64'(illegal), 64'(ill));
      chk("done_busy", 64'(busy), 64'd0);
      chk("done_issue", 64'(issue), 64'd0);
      chk("done_req", 64'(imem_req), 64'd0);
      chk("issues_left", 64'(exp_q.size()), 64'd0);
      chk("fetches_left", 64'(fetch_q.size()), 64'd0);
    end
    exp_q.delete();
    fetch_q.delete();
    lat_q.delete();
  endtask

  task automatic fill_random(input bit legal_only);
    logic [31:0] rnd;
    logic [3:0]  op;
    int          r;
    for (int i = 0; i < 256; i++) begin
      rnd = $urandom;
      r   = $urandom_range(0, 99);
      if (legal_only || r < 70) op = 4'($urandom_range(0, 6));
      else if (r < 88)          op = 4'($urandom_range(7, 14));
      else                      op = 4'hF;
      mem[i] = {op, rnd[15:0]};
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    fill_random(1'b0);

    // Reset with start held high: everything quiet.
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_fields", 64'({opcode, rd, rs, rt}), 64'd0);
    chk("rst_issue", 64'(issue), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_flags", 64'({busy, done, illegal}), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // ADD then SW then HALT, zero-wait memory.
    mem[0] = 20'h20000; mem[1] = 20'h60000; mem[2] = 20'hF0000;
    run_prog(0);

    // Five wait states on every fetch.
    mem[0] = 20'h1A5C6; mem[1] = 20'hF0000;
    run_prog(5);

    // Illegal opcode skipped, ADD after it still issued.
    mem[0] = 20'hA1234; mem[1] = 20'h20842; mem[2] = 20'hF0000;
    run_prog(0);
    // Restart with a clean program must clear the sticky flag.
    mem[0] = 20'h30000; mem[1] = 20'hF0000;
    run_prog(1);

    // End of program without HALT.
    fill_random(1'b1);
    run_prog(-1);

    // Reset while FETCH waits on a slow ack; late acks afterwards are ignored.
    @(negedge clk);
    lat_q.push_back(40);
    fetch_q.push_back(0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("wait_req", 64'(imem_req), 64'd1);
    chk("wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_req", 64'(imem_req), 64'd0);
    chk("midrst_pc", 64'(pc), 64'd0);
    chk("midrst_flags", 64'({busy, done, issue}), 64'd0);
    lat_q.delete();
    fetch_q.delete();
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    force_ack = 1'b0;
    chk("late_ack_busy", 64'(busy), 64'd0);
    chk("late_ack_req", 64'(imem_req), 64'd0);
    mem[0] = 20'h5FFFE; mem[1] = 20'hF0000;
    run_prog(2);

    // Random programs with random latencies.
    for (int n = 0; n < 30; n++) begin
      fill_random(1'b0);
      run_prog(-1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
